// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU status/flag pipeline stage.
package alu_pkg;

  // Bit positions of each flag inside the 4-bit {N,Z,C,O} flag word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;

  // Flag word; declaration order puts n in bit 3 and o in bit 0.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic o;
  } flags_t;

  // Occupancy of the head/skid buffer pair.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear.
// A clear that coincides with an event restarts the count at one, so the
// event seen in the clearing cycle is not lost.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Count register: clear wins over increment, increment stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else if (clr) begin
      count_r <= inc ? CNT_ONE : CNT_ZERO;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/alu_status_pipe.sv
// Registered flag/result stage behind the ALU adder and overflow-flag selector.
// Results are captured with derived N/Z/C/O flags into a head register and a
// one-entry skid register, so in_ready depends only on local state.
// A sticky overflow bit and a saturating overflow counter track accepted
// overflows for the control unit.
module alu_status_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_cout,
  input  logic             in_oflag,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  input  logic             clr_sticky,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] ovf_count
);

  buf_state_t       state_r;
  buf_state_t       state_nxt_s;
  logic [WIDTH-1:0] h_result_r;
  logic [WIDTH-1:0] h_result_nxt_s;
  logic [WIDTH-1:0] s_result_r;
  logic [WIDTH-1:0] s_result_nxt_s;
  flags_t           h_flags_r;
  flags_t           h_flags_nxt_s;
  flags_t           s_flags_r;
  flags_t           s_flags_nxt_s;
  flags_t           in_flags_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             sticky_r;
  logic             accept_s;
  logic             pop_s;
  logic             ovf_accept_s;

  assign accept_s     = in_valid & in_ready_r;
  assign pop_s        = out_valid_r & out_ready;
  assign ovf_accept_s = accept_s & in_flags_s.o;

  // Flag derivation; logic ops never report carry or overflow.
  always_comb begin
    in_flags_s   = 4'b0000;
    in_flags_s.n = in_result[WIDTH-1];
    in_flags_s.z = (in_result == {WIDTH{1'b0}});
    in_flags_s.c = in_cout & in_mode;
    in_flags_s.o = in_oflag & in_mode;
  end

  // Buffer next-state and head/skid register next values.
  always_comb begin
    state_nxt_s    = state_r;
    h_result_nxt_s = h_result_r;
    h_flags_nxt_s  = h_flags_r;
    s_result_nxt_s = s_result_r;
    s_flags_nxt_s  = s_flags_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_nxt_s    = ONE;
          h_result_nxt_s = in_result;
          h_flags_nxt_s  = in_flags_s;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && pop_s) begin
          state_nxt_s    = ONE;
          h_result_nxt_s = in_result;
          h_flags_nxt_s  = in_flags_s;
        end else if (accept_s) begin
          state_nxt_s    = FULL;
          s_result_nxt_s = in_result;
          s_flags_nxt_s  = in_flags_s;
        end else if (pop_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = ONE;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can move the buffer.
        if (pop_s) begin
          state_nxt_s    = ONE;
          h_result_nxt_s = s_result_r;
          h_flags_nxt_s  = s_flags_r;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // Buffer state, storage and handshake outputs registered from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      h_result_r  <= {WIDTH{1'b0}};
      h_flags_r   <= 4'b0000;
      s_result_r  <= {WIDTH{1'b0}};
      s_flags_r   <= 4'b0000;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      h_result_r  <= h_result_nxt_s;
      h_flags_r   <= h_flags_nxt_s;
      s_result_r  <= s_result_nxt_s;
      s_flags_r   <= s_flags_nxt_s;
      in_ready_r  <= (state_nxt_s != FULL);
      out_valid_r <= (state_nxt_s != EMPTY);
    end
  end

  // Sticky overflow: a new accepted overflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 1'b0;
    end else if (ovf_accept_s) begin
      sticky_r <= 1'b1;
    end else if (clr_sticky) begin
      sticky_r <= 1'b0;
    end else begin
      sticky_r <= sticky_r;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ovf_accept_s),
    .clr   (clr_sticky),
    .count (ovf_count)
  );

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = h_result_r;
  assign out_flags  = h_flags_r;
  assign sticky_ovf = sticky_r;

endmodule

// File: tb/tb_alu_status_pipe.sv
// Self-checking bench for alu_status_pipe. Two instances (8-bit and 4-bit
// counters) share stimulus; a queue-based model tracks the expected contents.
module tb_alu_status_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_result;
  logic       in_cout;
  logic       in_oflag;
  logic       in_mode;
  logic       out_ready;
  logic       clr_sticky;

  logic       a_in_ready, a_out_valid, a_sticky;
  logic [7:0] a_out_result;
  logic [3:0] a_out_flags;
  logic [7:0] a_count;

  logic       b_in_ready, b_out_valid, b_sticky;
  logic [7:0] b_out_result;
  logic [3:0] b_out_flags;
  logic [3:0] b_count;

  alu_status_pipe #(.WIDTH(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_result(in_result), .in_cout(in_cout), .in_oflag(in_oflag), .in_mode(in_mode),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_result(a_out_result),
    .out_flags(a_out_flags), .clr_sticky(clr_sticky), .sticky_ovf(a_sticky),
    .ovf_count(a_count)
  );

  alu_status_pipe #(.WIDTH(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_result(in_result), .in_cout(in_cout), .in_oflag(in_oflag), .in_mode(in_mode),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_result(b_out_result),
    .out_flags(b_out_flags), .clr_sticky(clr_sticky), .sticky_ovf(b_sticky),
    .ovf_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
  } ent_t;

  typedef struct {
    logic       v;
    logic [7:0] r;
    logic       c;
    logic       o;
    logic       m;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_res;
    logic [3:0] e_flg;
    logic       e_sticky;
    logic [7:0] e_cnt;
  } vec_t;

  ent_t q[$];
  int   m_sticky;
  int   m_cnt8;
  int   m_cnt4;
  int   n_checks;
  int   n_pass;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_flags(input logic [7:0] r, input logic c,
                                             input logic o, input logic m);
    logic [3:0] f;
    f = 4'b0000;
    f[3] = (r >= 8'd128);
    f[2] = (r == 8'd0);
    f[1] = c && m;
    f[0] = o && m;
    return f;
  endfunction

  task automatic compare_model();
    check("a_in_ready", {31'd0, a_in_ready}, {31'd0, (q.size() < 2)});
    check("b_in_ready", {31'd0, b_in_ready}, {31'd0, (q.size() < 2)});
    check("a_out_valid", {31'd0, a_out_valid}, {31'd0, (q.size() > 0)});
    check("b_out_valid", {31'd0, b_out_valid}, {31'd0, (q.size() > 0)});
    if (q.size() > 0) begin
      check("a_out_result", {24'd0, a_out_result}, {24'd0, q[0].res});
      check("a_out_flags", {28'd0, a_out_flags}, {28'd0, q[0].flg});
      check("b_out_result", {24'd0, b_out_result}, {24'd0, q[0].res});
      check("b_out_flags", {28'd0, b_out_flags}, {28'd0, q[0].flg});
    end
    check("a_sticky", {31'd0, a_sticky}, m_sticky);
    check("b_sticky", {31'd0, b_sticky}, m_sticky);
    check("a_count", {24'd0, a_count}, m_cnt8);
    check("b_count", {28'd0, b_count}, m_cnt4);
  endtask

  // One clock cycle: drive inputs, advance model across the edge, compare.
  task automatic step(input logic v, input logic [7:0] r, input logic c, input logic o,
                      input logic m, input logic rdy, input logic clr);
    logic acc;
    logic pop;
    logic ovf;
    ent_t e;
    in_valid   = v;
    in_result  = r;
    in_cout    = c;
    in_oflag   = o;
    in_mode    = m;
    out_ready  = rdy;
    clr_sticky = clr;
    acc = v && (q.size() < 2);
    pop = rdy && (q.size() > 0);
    ovf = acc && o && m;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) begin
      e.res = r;
      e.flg = model_flags(r, c, o, m);
      q.push_back(e);
    end
    if (ovf) m_sticky = 1;
    else if (clr) m_sticky = 0;
    if (clr) begin
      m_cnt8 = ovf ? 1 : 0;
      m_cnt4 = ovf ? 1 : 0;
    end else if (ovf) begin
      m_cnt8 = (m_cnt8 >= 255) ? 255 : m_cnt8 + 1;
      m_cnt4 = (m_cnt4 >= 15) ? 15 : m_cnt4 + 1;
    end
    #1;
    compare_model();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, {31'd0, a_out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, a_in_ready}, 32'd1);
    check({tag, "_out_result"}, {24'd0, a_out_result}, 32'd0);
    check({tag, "_out_flags"}, {28'd0, a_out_flags}, 32'd0);
    check({tag, "_sticky"}, {31'd0, a_sticky}, 32'd0);
    check({tag, "_count_a"}, {24'd0, a_count}, 32'd0);
    check({tag, "_count_b"}, {28'd0, b_count}, 32'd0);
    check({tag, "_b_out_valid"}, {31'd0, b_out_valid}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_sticky = 0;
    m_cnt8   = 0;
    m_cnt4   = 0;
    rst_n = 1'b1;
    in_valid = 1'b0; in_result = 8'h00; in_cout = 1'b0; in_oflag = 1'b0;
    in_mode = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //            v     r      c     o     m     rdy   clr   e_v   e_res  e_flg    e_st  e_cnt
    tbl[0] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'b0111, 1'b1, 8'd1};
    tbl[1] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 4'b1000, 1'b1, 8'd1};
    tbl[2] = '{1'b1, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h7F, 4'b0001, 1'b1, 8'd2};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 8'd0};
    tbl[4] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 4'b1010, 1'b0, 8'd0};
    tbl[5] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 4'b0001, 1'b1, 8'd1};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].r, tbl[i].c, tbl[i].o, tbl[i].m, tbl[i].rdy, tbl[i].clr);
      check($sformatf("tbl%0d_valid", i), {31'd0, a_out_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        check($sformatf("tbl%0d_result", i), {24'd0, a_out_result}, {24'd0, tbl[i].e_res});
        check($sformatf("tbl%0d_flags", i), {28'd0, a_out_flags}, {28'd0, tbl[i].e_flg});
      end
      check($sformatf("tbl%0d_sticky", i), {31'd0, a_sticky}, {31'd0, tbl[i].e_sticky});
      check($sformatf("tbl%0d_count", i), {24'd0, a_count}, {24'd0, tbl[i].e_cnt});
    end

    // Backpressure: third push must be held upstream, then drain in order.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_ready_after1", {31'd0, a_in_ready}, 32'd1);
    step(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_ready_after2", {31'd0, a_in_ready}, 32'd0);
    step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_held_ready", {31'd0, a_in_ready}, 32'd0);
    check("bp_head1", {24'd0, a_out_result}, 32'd1);
    step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_head2", {24'd0, a_out_result}, 32'd2);
    step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_head3", {24'd0, a_out_result}, 32'd3);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_drained", {31'd0, a_out_valid}, 32'd0);

    // Saturation of the 4-bit counter after 20 overflows, then clear+overflow.
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(i + 1), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    check("sat_count4", {28'd0, b_count}, 32'd15);
    check("sat_count8", {24'd0, a_count}, 32'd20);
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_ovf_count4", {28'd0, b_count}, 32'd1);
    check("clr_ovf_sticky", {31'd0, b_sticky}, 32'd1);

    // Streaming at one entry per cycle.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("stream%0d_ready", i), {31'd0, a_in_ready}, 32'd1);
      check($sformatf("stream%0d_result", i), {24'd0, a_out_result}, i);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset while the buffer is full and counters are non-zero.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_reset_full", {31'd0, a_in_ready}, 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_reset");
    q.delete();
    m_sticky = 0;
    m_cnt8   = 0;
    m_cnt4   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h42, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("post_reset_result", {24'd0, a_out_result}, 32'h42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
